// File: rtl/rx_frame_pkg.sv
// rtl/rx_frame_pkg.sv - shared state encoding, defaults and bit-serial CRC-8 for rx_frame_sync
package rx_frame_pkg;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_LEN,
    ST_PAYLOAD,
    ST_CRC
  } frame_state_t;

  localparam logic [31:0] SYNC_WORD_DEF = 32'h1ACF_FC1D;
  localparam logic [7:0]  CRC_POLY_DEF  = 8'h07;

  // MSB-first CRC-8, no reflection: feedback is the outgoing MSB xor the incoming bit
  function automatic logic [7:0] crc8_bit(input logic [7:0] crc, input logic b,
                                          input logic [7:0] poly = CRC_POLY_DEF);
    logic fb;
    fb = crc[7] ^ b;
    return {crc[6:0], 1'b0} ^ (fb ? poly : 8'h00);
  endfunction

endpackage

// File: rtl/sync_correlator.sv
// rtl/sync_correlator.sv - 32-bit sync shift register with registered mismatch count
module sync_correlator import rx_frame_pkg::*; #(
  parameter logic [31:0] SYNC_WORD = SYNC_WORD_DEF,
  parameter int unsigned MAX_ERR   = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic shift_en_i,
  input  logic bit_i,
  input  logic clear_i,
  output logic hit_o,
  output logic inverted_o
);

  localparam logic [5:0] LO_LIM = 6'(MAX_ERR);
  localparam logic [5:0] HI_LIM = 6'(32 - MAX_ERR);

  logic [31:0] sr_q, sr_d;
  logic [5:0]  dist_q, dist_d;
  logic        chk_q;

  always_comb begin
    sr_d   = {sr_q[30:0], bit_i};
    dist_d = '0;
    for (int i = 0; i < 32; i++) begin
      dist_d = dist_d + 6'(sr_d[i] ^ SYNC_WORD[i]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q   <= '0;
      dist_q <= '0;
      chk_q  <= 1'b0;
    end else if (clear_i) begin
      sr_q   <= '0;
      dist_q <= '0;
      chk_q  <= 1'b0;
    end else begin
      chk_q <= shift_en_i;
      if (shift_en_i) begin
        sr_q   <= sr_d;
        dist_q <= dist_d;
      end
    end
  end

  // chk_q marks the single cycle in which dist_q reflects a freshly shifted bit
  assign inverted_o = dist_q >= HI_LIM;
  assign hit_o      = chk_q && ((dist_q <= LO_LIM) || inverted_o);

endmodule

// File: rtl/rx_frame_sync.sv
// rtl/rx_frame_sync.sv - sync hunt, length/payload/CRC-8 parsing and AXI-S byte output
module rx_frame_sync import rx_frame_pkg::*; #(
  parameter logic [31:0] SYNC_WORD = SYNC_WORD_DEF,
  parameter int unsigned MAX_ERR   = 2,
  parameter logic [7:0]  CRC_POLY  = CRC_POLY_DEF
) (
  input  logic        clk_16M384,
  input  logic        rst_16M384,
  input  logic        frame_en,
  input  logic        bit_in,
  input  logic        bit_vld,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        m_tuser,
  output logic        sync_locked,
  output logic        phase_inv,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt,
  output logic        overflow
);

  frame_state_t state_q, state_d;
  logic        phase_inv_q, phase_inv_d;
  logic        locked_q, locked_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  crc_q, crc_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d;
  logic        frame_ovf_q, frame_ovf_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_vld_q, out_vld_d;
  logic        out_last_q, out_last_d;
  logic        out_user_q, out_user_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        overflow_q, overflow_d;

  logic       hit, inverted, corr_clear;
  logic       frame_bit, take_bit, byte_done, crc_bad;
  logic [7:0] byte_val, crc_next;
  logic       emit, emit_last, emit_user, drop, frame_done;

  sync_correlator #(.SYNC_WORD(SYNC_WORD), .MAX_ERR(MAX_ERR)) u_corr (
    .clk_i      (clk_16M384),
    .rst_i      (rst_16M384),
    .shift_en_i (bit_vld && frame_en),
    .bit_i      (bit_in),
    .clear_i    (corr_clear),
    .hit_o      (hit),
    .inverted_o (inverted)
  );

  assign frame_bit = bit_in ^ phase_inv_q;
  assign take_bit  = frame_en && bit_vld && (state_q != ST_HUNT);
  assign byte_val  = {shift_q[6:0], frame_bit};
  assign byte_done = take_bit && (bit_cnt_q == 3'd7);
  assign crc_next  = crc8_bit(crc_q, frame_bit, CRC_POLY);
  assign crc_bad   = byte_val != crc_q;

  always_comb begin
    state_d     = state_q;
    phase_inv_d = phase_inv_q;
    locked_d    = locked_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    len_d       = len_q;
    byte_cnt_d  = byte_cnt_q;
    crc_d       = crc_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    frame_ovf_d = frame_ovf_q;
    emit        = 1'b0;
    emit_last   = 1'b0;
    emit_user   = 1'b0;
    frame_done  = 1'b0;
    corr_clear  = 1'b0;

    if (take_bit) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      shift_d   = byte_val;
    end

    if (!frame_en) begin
      state_d    = ST_HUNT;
      locked_d   = 1'b0;
      hold_vld_d = 1'b0;
      corr_clear = 1'b1;
    end else begin
      case (state_q)
        ST_HUNT: begin
          if (hit) begin
            state_d     = ST_LEN;
            phase_inv_d = inverted;
            locked_d    = 1'b1;
            bit_cnt_d   = '0;
            crc_d       = '0;
            frame_ovf_d = 1'b0;
            hold_vld_d  = 1'b0;
          end
        end
        ST_LEN: begin
          if (take_bit) crc_d = crc_next;
          if (byte_done) begin
            len_d      = byte_val;
            byte_cnt_d = '0;
            state_d    = (byte_val == 8'd0) ? ST_CRC : ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (take_bit) crc_d = crc_next;
          if (byte_done) begin
            // previous byte leaves only once its successor exists, so tlast can be known
            emit       = hold_vld_q;
            hold_d     = byte_val;
            hold_vld_d = 1'b1;
            byte_cnt_d = byte_cnt_q + 8'd1;
            if (byte_cnt_q + 8'd1 == len_q) state_d = ST_CRC;
          end
        end
        ST_CRC: begin
          if (byte_done) begin
            emit       = hold_vld_q;
            emit_last  = 1'b1;
            emit_user  = crc_bad || frame_ovf_q;
            frame_done = 1'b1;
            hold_vld_d = 1'b0;
            locked_d   = 1'b0;
            state_d    = ST_HUNT;
            corr_clear = 1'b1;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  assign drop = emit && out_vld_q && !m_tready;

  always_comb begin
    out_data_d  = out_data_q;
    out_vld_d   = out_vld_q;
    out_last_d  = out_last_q;
    out_user_d  = out_user_q;
    overflow_d  = overflow_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;

    if (emit && !drop) begin
      out_data_d = hold_q;
      out_vld_d  = 1'b1;
      out_last_d = emit_last;
      out_user_d = emit_user;
    end else if (out_vld_q && m_tready) begin
      out_vld_d = 1'b0;
    end

    if (drop) overflow_d = 1'b1;

    if (frame_done) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
      if (crc_bad || frame_ovf_q || drop) err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_16M384 or posedge rst_16M384) begin
    if (rst_16M384) begin
      state_q     <= ST_HUNT;
      phase_inv_q <= 1'b0;
      locked_q    <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      len_q       <= '0;
      byte_cnt_q  <= '0;
      crc_q       <= '0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      frame_ovf_q <= 1'b0;
      out_data_q  <= '0;
      out_vld_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_user_q  <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_inv_q <= phase_inv_d;
      locked_q    <= locked_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      len_q       <= len_d;
      byte_cnt_q  <= byte_cnt_d;
      crc_q       <= crc_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      frame_ovf_q <= frame_ovf_d | drop;
      out_data_q  <= out_data_d;
      out_vld_q   <= out_vld_d;
      out_last_q  <= out_last_d;
      out_user_q  <= out_user_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  assign m_tdata     = out_data_q;
  assign m_tvalid    = out_vld_q;
  assign m_tlast     = out_last_q;
  assign m_tuser     = out_user_q;
  assign sync_locked = locked_q;
  assign phase_inv   = phase_inv_q;
  assign frame_cnt   = frame_cnt_q;
  assign err_cnt     = err_cnt_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_rx_frame_sync.sv
// tb/tb_rx_frame_sync.sv - directed frame vectors with hand-computed CRC-8 trailers
module tb_rx_frame_sync;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_en = 1'b1;
  logic        bit_in = 1'b0;
  logic        bit_vld = 1'b0;
  logic        m_tready = 1'b1;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tlast, m_tuser;
  logic        sync_locked, phase_inv, overflow;
  logic [15:0] frame_cnt, err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0] beat_q[$];

  localparam logic [31:0] SW = 32'h1ACF_FC1D;
  // CRC-8 (poly 07, init 00) over 03 A5 5A 01, worked by hand
  localparam logic [7:0] CRC3 = 8'h3B;

  rx_frame_sync dut (
    .clk_16M384  (clk),
    .rst_16M384  (rst),
    .frame_en    (frame_en),
    .bit_in      (bit_in),
    .bit_vld     (bit_vld),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tlast     (m_tlast),
    .m_tuser     (m_tuser),
    .sync_locked (sync_locked),
    .phase_inv   (phase_inv),
    .frame_cnt   (frame_cnt),
    .err_cnt     (err_cnt),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready) beat_q.push_back({m_tlast, m_tuser, m_tdata});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_beat(input string tag, input logic [9:0] exp);
    logic [31:0] got;
    if (beat_q.size() == 0) got = 32'hDEAD;
    else got = {22'd0, beat_q.pop_front()};
    check(tag, got, {22'd0, exp});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    frame_en = 1'b1;
    bit_vld = 1'b0;
    m_tready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    beat_q.delete();
    @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n, input logic inv);
    for (int i = n - 1; i >= 0; i--) begin
      bit_in = v[i] ^ inv;
      bit_vld = 1'b1;
      @(negedge clk);
      bit_vld = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic send_frame3(input logic [31:0] sw, input logic [7:0] crc, input logic inv);
    send_bits(sw, 32, inv);
    send_bits(32'h03, 8, inv);
    send_bits(32'hA5, 8, inv);
    send_bits(32'h5A, 8, inv);
    send_bits(32'h01, 8, inv);
    send_bits({24'd0, crc}, 8, inv);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    // 1: clean frame, plus reset state
    do_reset();
    check("rst outs", {26'd0, m_tvalid, m_tlast, m_tuser, sync_locked, phase_inv, overflow}, 32'd0);
    check("rst frame_cnt", {16'd0, frame_cnt}, 32'd0);
    check("rst err_cnt", {16'd0, err_cnt}, 32'd0);
    send_bits(SW, 32, 1'b0);
    check("t1 locked", {31'd0, sync_locked}, 32'd1);
    send_bits(32'h03, 8, 1'b0);
    send_bits(32'hA5, 8, 1'b0);
    send_bits(32'h5A, 8, 1'b0);
    send_bits(32'h01, 8, 1'b0);
    send_bits({24'd0, CRC3}, 8, 1'b0);
    repeat (4) @(negedge clk);
    check("t1 nbeats", beat_q.size(), 32'd3);
    check_beat("t1 b0", 10'h0A5);
    check_beat("t1 b1", 10'h05A);
    check_beat("t1 b2", 10'h201);
    check("t1 frame_cnt", {16'd0, frame_cnt}, 32'd1);
    check("t1 err_cnt", {16'd0, err_cnt}, 32'd0);
    check("t1 unlocked", {31'd0, sync_locked}, 32'd0);

    // 2: two sync bit errors accepted, three rejected
    do_reset();
    send_frame3(SW ^ 32'h8000_0001, CRC3, 1'b0);
    check("t2a nbeats", beat_q.size(), 32'd3);
    check_beat("t2a b0", 10'h0A5);
    check_beat("t2a b1", 10'h05A);
    check_beat("t2a b2", 10'h201);
    check("t2a frame_cnt", {16'd0, frame_cnt}, 32'd1);
    do_reset();
    send_frame3(SW ^ 32'h8000_0003, CRC3, 1'b0);
    check("t2b nbeats", beat_q.size(), 32'd0);
    check("t2b frame_cnt", {16'd0, frame_cnt}, 32'd0);

    // 3: whole stream inverted
    do_reset();
    send_frame3(SW, CRC3, 1'b1);
    check("t3 phase_inv", {31'd0, phase_inv}, 32'd1);
    check("t3 nbeats", beat_q.size(), 32'd3);
    check_beat("t3 b0", 10'h0A5);
    check_beat("t3 b1", 10'h05A);
    check_beat("t3 b2", 10'h201);

    // 4: bad trailer
    do_reset();
    send_frame3(SW, CRC3 ^ 8'hFF, 1'b0);
    check("t4 nbeats", beat_q.size(), 32'd3);
    check_beat("t4 b0", 10'h0A5);
    check_beat("t4 b1", 10'h05A);
    check_beat("t4 b2", 10'h301);
    check("t4 err_cnt", {16'd0, err_cnt}, 32'd1);
    check("t4 frame_cnt", {16'd0, frame_cnt}, 32'd1);

    // 5: back-pressure across two byte times
    do_reset();
    send_bits(SW, 32, 1'b0);
    send_bits(32'h03, 8, 1'b0);
    send_bits(32'hA5, 8, 1'b0);
    m_tready = 1'b0;
    send_bits(32'h5A, 8, 1'b0);
    send_bits(32'h01, 8, 1'b0);
    check("t5 held vld", {31'd0, m_tvalid}, 32'd1);
    check("t5 held data", {24'd0, m_tdata}, 32'h0A5);
    check("t5 overflow", {31'd0, overflow}, 32'd1);
    m_tready = 1'b1;
    send_bits({24'd0, CRC3}, 8, 1'b0);
    repeat (4) @(negedge clk);
    check("t5 nbeats", beat_q.size(), 32'd2);
    check_beat("t5 b0", 10'h0A5);
    check_beat("t5 b1", 10'h301);
    check("t5 err_cnt", {16'd0, err_cnt}, 32'd1);
    check("t5 frame_cnt", {16'd0, frame_cnt}, 32'd1);

    // 6: empty frame, then abort mid-payload, then reset
    do_reset();
    send_bits(SW, 32, 1'b0);
    send_bits(32'h00, 8, 1'b0);
    send_bits(32'h00, 8, 1'b0);
    repeat (4) @(negedge clk);
    check("t6 frame_cnt", {16'd0, frame_cnt}, 32'd1);
    check("t6 err_cnt", {16'd0, err_cnt}, 32'd0);
    send_bits(SW, 32, 1'b0);
    send_bits(32'h02, 8, 1'b0);
    send_bits(32'hA5, 8, 1'b0);
    send_bits(32'h5, 4, 1'b0);
    check("t6 locked", {31'd0, sync_locked}, 32'd1);
    frame_en = 1'b0;
    @(negedge clk);
    check("t6 unlock", {31'd0, sync_locked}, 32'd0);
    send_bits(32'hA, 4, 1'b0);
    send_bits({24'd0, 8'h11}, 8, 1'b0);
    repeat (4) @(negedge clk);
    check("t6 nbeats", beat_q.size(), 32'd0);
    check("t6 frame_cnt2", {16'd0, frame_cnt}, 32'd1);
    do_reset();
    check("t6 rst frame_cnt", {16'd0, frame_cnt}, 32'd0);
    check("t6 rst state", {29'd0, sync_locked, overflow, m_tvalid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
